// File: rtl/four_bit_serializer_pkg.sv
// Shared types and widths for the four_bit_serializer slice (package ser_pkg).
package ser_pkg;

  localparam int WORD_W = 4;
  localparam int SEL_W  = 2;
  localparam int GAP_W  = 4;

  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(WORD_W - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    GAP    = 2'd3
  } ser_state_e;

endpackage

// File: rtl/four_bit_serializer_mux.sv
// 4-to-1 bit select used to pick the serial data bit out of the held word.
module four_to_one_mux
  import ser_pkg::*;
(
  input  logic [WORD_W-1:0] i,
  input  logic [SEL_W-1:0]  s,
  output logic              y
);

  always_comb begin
    y = i[s];
  end

endmodule

// File: rtl/four_bit_serializer.sv
// Parallel-to-serial front end: 4-bit word in, LSB-first beats out with select index.
// Optional even-parity fifth beat when SER_PARITY_EN is defined.
module four_bit_serializer
  import ser_pkg::*;
#(
  parameter int GAP_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_bit,
  output logic [SEL_W-1:0]  out_sel,
  output logic              out_last,
  output logic              busy
);

  // Handshakes: a transfer happens on the rising edge where valid & ready are
  // both high; valid never depends on ready, and the beat holds until taken.

  localparam logic [GAP_W-1:0] GAP_LOAD =
    (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;
  localparam ser_state_e AFTER_WORD = (GAP_CYCLES > 0) ? GAP : IDLE;

  ser_state_e        state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              mux_y;

  logic              beat_valid;
  logic              beat_bit;
  logic [SEL_W-1:0]  beat_sel;
  logic              beat_last;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    gap_d   = gap_q;
    word_d  = word_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          word_d  = in_data;
          sel_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (out_ready) begin
          if (sel_q == LAST_SEL) begin
            sel_d = '0;
`ifdef SER_PARITY_EN
            state_d = PARITY;
`else
            state_d = AFTER_WORD;
            gap_d   = GAP_LOAD;
`endif
          end else begin
            sel_d = sel_q + 1'b1;
          end
        end
      end
      PARITY: begin
`ifdef SER_PARITY_EN
        if (out_ready) begin
          state_d = AFTER_WORD;
          gap_d   = GAP_LOAD;
        end
`else
        state_d = IDLE;
`endif
      end
      GAP: begin
        if (gap_q == '0) state_d = IDLE;
        else             gap_d   = gap_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Fed from next-state values so the registered bit lines up with out_sel.
  four_to_one_mux u_mux (
    .i (word_d),
    .s (sel_d),
    .y (mux_y)
  );

  always_comb begin
    beat_valid = 1'b0;
    beat_bit   = 1'b0;
    beat_sel   = '0;
    beat_last  = 1'b0;
    if (state_d == SHIFT) begin
      beat_valid = 1'b1;
      beat_bit   = mux_y;
      beat_sel   = sel_d;
`ifndef SER_PARITY_EN
      beat_last  = (sel_d == LAST_SEL);
`endif
    end
`ifdef SER_PARITY_EN
    else if (state_d == PARITY) begin
      beat_valid = 1'b1;
      beat_bit   = ^word_d;
      beat_sel   = LAST_SEL;
      beat_last  = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      gap_q     <= '0;
      word_q    <= '0;
      out_valid <= 1'b0;
      out_bit   <= 1'b0;
      out_sel   <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      gap_q     <= gap_d;
      word_q    <= word_d;
      out_valid <= beat_valid;
      out_bit   <= beat_bit;
      out_sel   <= beat_sel;
      out_last  <= beat_last;
      busy      <= (state_d != IDLE);
    end
  end

  // Held low while rst is asserted, rises as soon as it releases.
  assign in_ready = ~busy & ~rst;

endmodule
